seq_frame_tx: RTL
=================

// Module: seq_frame_tx
// PURPOSE
//  Serial frame transmitter: accepts a parallel payload word via valid/ready, emits one bit per
//  clock on a single-bit line as PREAMBLE (default 101) + payload MSB-first + GAP zeros.
//  Drives the data input of the downstream 101 sequence detector; preamble marks frame start.
//  Idle line level is 0.
// PARAMETERS
//  WIDTH     8        payload bits per frame (>=1)
//  PRE_LEN   3        preamble length in bits (>=1)
//  PREAMBLE  3'b101   preamble pattern [PRE_LEN-1:0], sent MSB-first
//  GAP_LEN   2        trailing zero bits after payload (>=1); flushes receiver state
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  in_valid     in   1      payload word offered
//  in_data      in   WIDTH  payload word, sampled on accept
//  in_ready     out  1      transmitter can accept a word this cycle
//  data         out  1      serial line, registered
//  busy         out  1      frame in progress (PREAMBLE/PAYLOAD/GAP)
//  frame_done   out  1      one-cycle pulse, see below
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, data=0, busy=0, frame_done=0, shift reg and counter=0.
//    Mid-frame reset aborts the frame; word discarded; nothing resumes.
//  - States: IDLE -> PREAMBLE -> PAYLOAD -> GAP -> IDLE (or GAP -> PREAMBLE on back-to-back).
//  - in_ready = (state==IDLE) | (state==GAP & last gap bit on line). Combinational from state/cnt.
//  - Accept = in_valid & in_ready at a rising edge: in_data latched into shift reg, cnt=0,
//    state->PREAMBLE; data = PREAMBLE[PRE_LEN-1] in the cycle after the accept edge (latency 1).
//  - PREAMBLE: one bit/cycle, PREAMBLE[PRE_LEN-1] down to [0]; after PRE_LEN cycles -> PAYLOAD.
//  - PAYLOAD: data = in_data[WIDTH-1] down to [0], shift left each cycle; after WIDTH -> GAP.
//  - GAP: data=0 for GAP_LEN cycles; frame_done=1 during the last GAP cycle only.
//    Accept in that cycle -> PREAMBLE next cycle (no idle bit); else -> IDLE.
//  - Frame length exactly PRE_LEN+WIDTH+GAP_LEN cycles; back-to-back period identical.
//  - in_valid while not in_ready: ignored, in_data not sampled, no error flagged.
//  - busy = (state != IDLE), registered with state. data=0 in IDLE.
//  - Counter width $clog2(max(PRE_LEN,WIDTH,GAP_LEN)+1); resets to 0 on every state change.
//  - Undefined/illegal state encoding -> IDLE next cycle, data=0.
// STRUCTURE
//  - Shared package seq_pkg: typedef enum logic [1:0] {TX_IDLE, TX_PREAMBLE, TX_PAYLOAD, TX_GAP}
//    tx_state_t; localparam SEQ_PREAMBLE_101 = 3'b101 (also the detector's target sequence).
//  - Sub-module piso_shift #(WIDTH): load/shift-enable parallel-in serial-out register,
//    async active-high reset, MSB out. FSM, counter, output register stay in seq_frame_tx.
//  - Two-process style: always_ff for state/cnt/data, always_comb for next-state/outputs.
// TESTING (WIDTH=8, PRE_LEN=3, PREAMBLE=101, GAP_LEN=2)
//  1. reset=1 then 0, in_valid=0 for 5 cycles -> data=0, busy=0, in_ready=1, frame_done=0.
//  2. accept in_data=8'hA5 -> data over 13 cycles = 1,0,1, 1,0,1,0,0,1,0,1, 0,0;
//     frame_done high only on 13th bit; then IDLE.
//  3. in_valid held high with 8'hA5 then 8'h3C -> 26 contiguous bits, no idle gap;
//     second frame = 1,0,1,0,0,1,1,1,1,0,0,0,0.
//  4. in_valid=1 with 8'hFF during PAYLOAD of frame 1 -> in_ready=0, word ignored, frame 1 unchanged.
//  5. reset pulse at bit 6 of frame -> data=0, busy=0 same cycle (async); next accept starts clean 101.
//  6. Loopback into 101 detector: one detection per frame at preamble end plus payload hits;
//     8'h00 payload -> exactly one detection.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame transmitter and the downstream
// 101 sequence detector: FSM state encoding, the default preamble pattern and
// a small helper used to size counters.
package seq_pkg;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_PREAMBLE = 2'd1,
    TX_PAYLOAD  = 2'd2,
    TX_GAP      = 2'd3
  } tx_state_t;

  // Frame-start marker; also the pattern the downstream detector looks for.
  localparam logic [2:0] SEQ_PREAMBLE_101 = 3'b101;

  // Largest of three lengths, used to size a shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/seq_frame_tx_piso.sv
// Parallel-in serial-out shift register. Load has priority over shift; the
// serial output is the MSB, and each shift moves the next bit into the MSB.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  // Hold, load a new word, or shift left by one (zero fill).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_data;
    end else if (shift_en) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: PREAMBLE + payload (MSB first) + GAP zeros, one
// bit per clock on a registered line that idles low.
//
// Handshake: a word is accepted on a rising edge where in_valid & in_ready.
// in_ready depends only on state/counter (never on in_valid); it is high in
// IDLE and during the last GAP bit, so back-to-back frames have no idle bit.
// in_valid while in_ready is low is ignored and in_data is not sampled.
module seq_frame_tx import seq_pkg::*; #(
  parameter int                 WIDTH    = 8,
  parameter int                 PRE_LEN  = 3,
  parameter logic [PRE_LEN-1:0] PREAMBLE = SEQ_PREAMBLE_101,
  parameter int                 GAP_LEN  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             data,
  output logic             busy,
  output logic             frame_done,
  output tx_state_t        state_dbg
);

  localparam int CNT_MAX = max3(PRE_LEN, WIDTH, GAP_LEN);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

  tx_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               data_q, data_d;
  logic               busy_q;
  logic               load, shift_en;
  logic               sr_msb;
  logic [PRE_LEN-1:0] pre_shifted;

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (in_data),
    .msb       (sr_msb)
  );

  // Next state, counter, handshake and the bit to put on the line next cycle.
  // The payload bit is taken from the shift register MSB on the same edge the
  // register shifts, so the register always holds the not-yet-sent bits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    shift_en    = 1'b0;
    in_ready    = 1'b0;
    frame_done  = 1'b0;
    data_d      = 1'b0;
    pre_shifted = '0;

    case (state_q)
      TX_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = TX_PREAMBLE;
          cnt_d   = '0;
        end
      end
      TX_PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d  = TX_PAYLOAD;
          cnt_d    = '0;
          shift_en = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_PAYLOAD: begin
        if (cnt_q == PAY_LAST) begin
          state_d = TX_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          shift_en = 1'b1;
        end
      end
      TX_GAP: begin
        if (cnt_q == GAP_LAST) begin
          in_ready   = 1'b1;
          frame_done = 1'b1;
          cnt_d      = '0;
          if (in_valid) begin
            load    = 1'b1;
            state_d = TX_PREAMBLE;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Preamble bit index counts down from PRE_LEN-1 as the counter counts up.
    pre_shifted = PREAMBLE << cnt_d;
    case (state_d)
      TX_PREAMBLE: data_d = pre_shifted[PRE_LEN-1];
      TX_PAYLOAD:  data_d = sr_msb;
      default:     data_d = 1'b0;
    endcase
  end

  // State, counter and the registered line/busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= (state_d != TX_IDLE);
    end
  end

  assign data      = data_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule
